// File: rtl/mc_controller.sv
// mc_controller: multi-cycle control FSM for a small MIPS subset.
// Define MC_CTRL_MEMWAIT_EN to add the mem_ready handshake and wait timeout.
module mc_controller #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic       mem_re,
  output logic       mem_we,
  output logic [2:0] alu_ctrl,
  output logic [1:0] alu_src_b,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_sel,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic       ext_sign,
  output logic       byte_en,
  output logic       instr_done,
  output logic       trap
);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
    WB_ALU, WB_MEM, BRANCH, JUMP, TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  state_t     state, state_nxt;
  logic [5:0] op_r, func_r;
  logic       mem_go;
  logic       timeout;

`ifdef MC_CTRL_MEMWAIT_EN
  logic [7:0] wait_cnt;
  logic       mem_state;

  assign mem_state = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  assign mem_go    = mem_ready;
  // The cycle that would make the count reach MEM_TIMEOUT diverts to TRAP.
  assign timeout   = mem_state && !mem_ready && (wait_cnt == 8'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           wait_cnt <= '0;
    else if (state_nxt != state)          wait_cnt <= '0;
    else if (mem_state && !mem_ready)     wait_cnt <= wait_cnt + 8'd1;
  end
`else
  logic unused_memwait;

  assign mem_go         = 1'b1;
  assign timeout        = 1'b0;
  assign unused_memwait = mem_ready ^ (MEM_TIMEOUT == 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_nxt;
  end

  // Later states decode from the copy captured in DECODE, not the live IR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_r   <= '0;
      func_r <= '0;
    end else if (state == DECODE) begin
      op_r   <= op;
      func_r <= func;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: begin
        if (timeout)     state_nxt = TRAP;
        else if (mem_go) state_nxt = DECODE;
      end
      DECODE: begin
        case (op)
          OP_RTYPE: begin
            case (func)
              FN_SLL, FN_ADDU, FN_SUBU: state_nxt = EXEC_R;
              FN_JR:                    state_nxt = JUMP;
              default:                  state_nxt = TRAP;
            endcase
          end
          OP_ORI, OP_LUI:      state_nxt = EXEC_I;
          OP_LW, OP_SW, OP_SB: state_nxt = MEM_ADDR;
          OP_BEQ:              state_nxt = BRANCH;
          OP_JAL:              state_nxt = JUMP;
          default:             state_nxt = TRAP;
        endcase
      end
      EXEC_R, EXEC_I: state_nxt = WB_ALU;
      MEM_ADDR:       state_nxt = (op_r == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD: begin
        if (timeout)     state_nxt = TRAP;
        else if (mem_go) state_nxt = WB_MEM;
      end
      MEM_WR: begin
        if (timeout)     state_nxt = TRAP;
        else if (mem_go) state_nxt = FETCH;
      end
      WB_ALU, WB_MEM, BRANCH, JUMP: state_nxt = FETCH;
      TRAP:    state_nxt = TRAP;
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    alu_ctrl   = 3'b000;
    alu_src_b  = 2'b00;
    reg_dst    = 2'b00;
    wb_sel     = 2'b00;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    ext_sign   = 1'b0;
    byte_en    = 1'b0;
    instr_done = 1'b0;
    trap       = 1'b0;
    case (state)
      FETCH: begin
        mem_re    = 1'b1;
        ir_we     = mem_go;
        pc_we     = mem_go;
        alu_src_b = 2'b01;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        ext_sign  = 1'b1;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_ctrl  = (func_r == FN_SUBU) ? 3'b001 : 3'b000;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = (op_r == OP_LUI) ? 3'b011 : 3'b010;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_sign  = 1'b1;
      end
      MEM_RD: mem_re = 1'b1;
      MEM_WR: begin
        mem_we     = mem_go;
        byte_en    = (op_r == OP_SB);
        instr_done = mem_go;
      end
      WB_ALU: begin
        reg_we     = 1'b1;
        reg_dst    = (op_r == OP_RTYPE) ? 2'b01 : 2'b00;
        instr_done = 1'b1;
      end
      WB_MEM: begin
        reg_we     = 1'b1;
        wb_sel     = 2'b01;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_ctrl   = 3'b001;
        ext_sign   = 1'b1;
        pc_src     = 2'b01;
        pc_we      = zero;
        instr_done = 1'b1;
      end
      JUMP: begin
        pc_we      = 1'b1;
        instr_done = 1'b1;
        if (op_r == OP_JAL) begin
          pc_src  = 2'b10;
          reg_we  = 1'b1;
          reg_dst = 2'b10;
          wb_sel  = 2'b10;
        end else begin
          pc_src  = 2'b11;
        end
      end
      TRAP:    trap = 1'b1;
      default: ;
    endcase
    // Outputs stay quiet while reset is held, even though state already reads FETCH.
    if (!reset) begin
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      reg_we     = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      alu_ctrl   = 3'b000;
      alu_src_b  = 2'b00;
      reg_dst    = 2'b00;
      wb_sel     = 2'b00;
      pc_src     = 2'b00;
      alu_src_a  = 1'b0;
      ext_sign   = 1'b0;
      byte_en    = 1'b0;
      instr_done = 1'b0;
      trap       = 1'b0;
    end
  end

endmodule
